// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the serial magnitude comparator
package cmp_pkg;
    typedef enum logic {IDLE, COMPARE} state_t;
    typedef enum logic [1:0] {RES_EQ, RES_LT, RES_GT} result_t;
    function automatic logic [2:0] to_leg(result_t r);
        return r == RES_LT ? 3'b100 : r == RES_GT ? 3'b001 : 3'b010;
    endfunction
endpackage

// File: rtl/comparator_1bit_dataflow_design.sv
// comparator_1bit_dataflow_design: combinational 1-bit L/E/G classifier
module comparator_1bit_dataflow_design (
    input  logic a,
    input  logic b,
    output logic L,
    output logic E,
    output logic G
);
    assign L = ~a & b;
    assign E = ~(a ^ b);
    assign G = a & ~b;
endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial A/B magnitude compare with registered L/E/G verdict and done pulse
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic decided,
    output logic done,
    output logic L,
    output logic E,
    output logic G
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_n;
    result_t res, res_n, bit_res, res_upd;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] leg, leg_n;
    logic dec_q, dec_n, done_q, done_n;
    logic bit_l, bit_e, bit_g;
    comparator_1bit_dataflow_design u_bit (
        .a(a_bit),
        .b(b_bit),
        .L(bit_l),
        .E(bit_e),
        .G(bit_g)
    );
    assign bit_res = bit_l ? RES_LT : bit_g ? RES_GT : RES_EQ;
    // MSB-first: first differing bit wins; LSB-first: latest differing bit wins
    assign res_upd = MSB_FIRST ? (res == RES_EQ ? bit_res : res) : (bit_e ? res : bit_res);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            res    <= RES_EQ;
            dec_q  <= 1'b0;
            done_q <= 1'b0;
            leg    <= 3'b000;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            res    <= res_n;
            dec_q  <= dec_n;
            done_q <= done_n;
            leg    <= leg_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        res_n   = res;
        dec_n   = dec_q;
        done_n  = 1'b0;
        leg_n   = leg;
        if (state == IDLE) begin
            if (start) begin
                state_n = COMPARE;
                cnt_n   = '0;
                res_n   = RES_EQ;
                dec_n   = 1'b0;
                leg_n   = 3'b000;
            end
        end else if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            res_n   = RES_EQ;
            dec_n   = 1'b0;
            leg_n   = 3'b000;
        end else if (bit_valid) begin
            res_n = res_upd;
            dec_n = MSB_FIRST && (dec_q || !bit_e);
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                done_n  = 1'b1;
                leg_n   = to_leg(res_upd);
            end
        end
    end
    assign busy    = state == COMPARE;
    assign decided = dec_q;
    assign done    = done_q;
    assign {L, E, G} = leg;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed checks of MSB-first and LSB-first serial comparators
module tb_serial_magnitude_comparator;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
    logic o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G;
    logic o0_busy, o0_decided, o0_done, o0_L, o0_E, o0_G;
    int n_cmp = 0, n_bad = 0;

    serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(o1_busy), .decided(o1_decided), .done(o1_done),
        .L(o1_L), .E(o1_E), .G(o1_G)
    );
    serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(o0_busy), .decided(o0_decided), .done(o0_done),
        .L(o0_L), .E(o0_E), .G(o0_G)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic a, input logic b);
        bit_valid = 1'b1;
        a_bit = a;
        b_bit = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] a, input logic [7:0] b, input bit lsb_first);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = lsb_first ? i : 7 - i;
            beat(a[idx], b[idx]);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_msb got=%b want=000000", {o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G});
        end
        n_cmp++;
        if ({o0_busy, o0_decided, o0_done, o0_L, o0_E, o0_G} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_lsb got=%b want=000000", {o0_busy, o0_decided, o0_done, o0_L, o0_E, o0_G});
        end
        #10 rst_n = 1'b1;
        step();
    endtask

    task automatic test_equal();
        logic [7:0] a = 8'hA5, b = 8'hA5;
        do_start();
        n_cmp++;
        if (o1_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL eq_busy got=%b want=1", o1_busy);
        end
        for (int i = 7; i >= 0; i--) begin
            beat(a[i], b[i]);
            if (i > 0) begin
                n_cmp++;
                if ({o1_done, o1_decided} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL eq_early beat=%0d done,decided got=%b want=00", 8 - i, {o1_done, o1_decided});
                end
            end
        end
        n_cmp++;
        if ({o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G} !== 6'b001010) begin
            n_bad++;
            $display("FAIL eq_done busy,dec,done,LEG got=%b want=001010", {o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G});
        end
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        n_cmp++;
        if ({o1_busy, o1_done, o1_L, o1_E, o1_G} !== 5'b00010) begin
            n_bad++;
            $display("FAIL idle_bits busy,done,LEG got=%b want=00010", {o1_busy, o1_done, o1_L, o1_E, o1_G});
        end
    endtask

    task automatic test_msb_decide();
        logic [7:0] a = 8'h80, b = 8'h7F;
        do_start();
        beat(a[7], b[7]);
        n_cmp++;
        if (o1_decided !== 1'b1) begin
            n_bad++;
            $display("FAIL msb_decided got=%b want=1", o1_decided);
        end
        for (int i = 6; i >= 0; i--) beat(a[i], b[i]);
        n_cmp++;
        if ({o1_done, o1_L, o1_E, o1_G} !== 4'b1001) begin
            n_bad++;
            $display("FAIL msb_gt done,LEG got=%b want=1001", {o1_done, o1_L, o1_E, o1_G});
        end
        do_start();
        n_cmp++;
        if ({o1_decided, o1_L, o1_E, o1_G} !== 4'b0000) begin
            n_bad++;
            $display("FAIL start_clear dec,LEG got=%b want=0000", {o1_decided, o1_L, o1_E, o1_G});
        end
        feed(8'h3C, 8'h3D, 1'b0);
        n_cmp++;
        if ({o1_done, o1_decided, o1_L, o1_E, o1_G} !== 5'b11100) begin
            n_bad++;
            $display("FAIL msb_lt done,dec,LEG got=%b want=11100", {o1_done, o1_decided, o1_L, o1_E, o1_G});
        end
    endtask

    task automatic test_lsb();
        do_start();
        feed(8'h01, 8'h02, 1'b1);
        n_cmp++;
        if ({o0_done, o0_decided, o0_L, o0_E, o0_G} !== 5'b10100) begin
            n_bad++;
            $display("FAIL lsb_lt done,dec,LEG got=%b want=10100", {o0_done, o0_decided, o0_L, o0_E, o0_G});
        end
        do_start();
        feed(8'hF0, 8'h0F, 1'b1);
        n_cmp++;
        if ({o0_done, o0_decided, o0_L, o0_E, o0_G} !== 5'b10001) begin
            n_bad++;
            $display("FAIL lsb_gt done,dec,LEG got=%b want=10001", {o0_done, o0_decided, o0_L, o0_E, o0_G});
        end
    endtask

    task automatic test_stall();
        logic [7:0] a = 8'h55, b = 8'h54;
        do_start();
        for (int i = 7; i >= 4; i--) beat(a[i], b[i]);
        bit_valid = 1'b0;
        a_bit = 1'b1;
        b_bit = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            n_cmp++;
            if ({o1_busy, o1_done, o1_decided} !== 3'b100) begin
                n_bad++;
                $display("FAIL stall cycle=%0d busy,done,dec got=%b want=100", s, {o1_busy, o1_done, o1_decided});
            end
        end
        for (int i = 3; i >= 0; i--) begin
            beat(a[i], b[i]);
            if (i == 1) begin
                n_cmp++;
                if (o1_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_early_done got=%b want=0", o1_done);
                end
            end
        end
        n_cmp++;
        if ({o1_done, o1_decided, o1_L, o1_E, o1_G} !== 5'b11001) begin
            n_bad++;
            $display("FAIL stall_done done,dec,LEG got=%b want=11001", {o1_done, o1_decided, o1_L, o1_E, o1_G});
        end
    endtask

    task automatic test_abort();
        logic [7:0] a = 8'h12, b = 8'h34;
        do_start();
        for (int i = 7; i >= 4; i--) beat(a[i], b[i]);
        n_cmp++;
        if (o1_decided !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre_dec got=%b want=1", o1_decided);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort busy,dec,done,LEG got=%b want=000000", {o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G});
        end
        step();
        n_cmp++;
        if (o1_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done got=%b want=0", o1_done);
        end
        do_start();
        feed(8'h10, 8'h10, 1'b0);
        n_cmp++;
        if ({o1_done, o1_L, o1_E, o1_G} !== 4'b1010) begin
            n_bad++;
            $display("FAIL post_abort_eq done,LEG got=%b want=1010", {o1_done, o1_L, o1_E, o1_G});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({o1_busy, o1_L, o1_E, o1_G} !== 4'b0010) begin
            n_bad++;
            $display("FAIL idle_abort busy,LEG got=%b want=0010", {o1_busy, o1_L, o1_E, o1_G});
        end
        do_start();
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b0);
        abort = 1'b1;
        beat(1'b1, 1'b0);
        abort = 1'b0;
        n_cmp++;
        if ({o1_busy, o1_done, o1_L, o1_E, o1_G} !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_last busy,done,LEG got=%b want=00000", {o1_busy, o1_done, o1_L, o1_E, o1_G});
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (o1_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_abort_idle busy got=%b want=1", o1_busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] a = 8'h0F, b = 8'h0E;
        do_start();
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G, o0_busy, o0_L, o0_E, o0_G} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_mid got=%b want=0000000000",
                     {o1_busy, o1_decided, o1_done, o1_L, o1_E, o1_G, o0_busy, o0_L, o0_E, o0_G});
        end
        #2 rst_n = 1'b1;
        step();
        do_start();
        start = 1'b1;
        for (int i = 7; i >= 4; i--) beat(a[i], b[i]);
        start = 1'b0;
        for (int i = 3; i >= 0; i--) beat(a[i], b[i]);
        n_cmp++;
        if ({o1_done, o1_L, o1_E, o1_G} !== 4'b1001) begin
            n_bad++;
            $display("FAIL busy_start_ignored done,LEG got=%b want=1001", {o1_done, o1_L, o1_E, o1_G});
        end
        do_start();
        n_cmp++;
        if ({o1_busy, o1_done, o1_L, o1_E, o1_G} !== 5'b10000) begin
            n_bad++;
            $display("FAIL b2b_start busy,done,LEG got=%b want=10000", {o1_busy, o1_done, o1_L, o1_E, o1_G});
        end
        feed(8'h00, 8'h01, 1'b0);
        n_cmp++;
        if ({o1_done, o1_L, o1_E, o1_G} !== 4'b1100) begin
            n_bad++;
            $display("FAIL b2b_done done,LEG got=%b want=1100", {o1_done, o1_L, o1_E, o1_G});
        end
        step();
        n_cmp++;
        if ({o1_done, o1_L, o1_E, o1_G} !== 4'b0100) begin
            n_bad++;
            $display("FAIL done_pulse_hold done,LEG got=%b want=0100", {o1_done, o1_L, o1_E, o1_G});
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_decide();
        test_lsb();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
